// File: rtl/ks_add_sequencer_if.sv
// Byte-stream bundle between the chip-pin byte interface and the add/sub sequencer.
// master drives operands and consumes results; slave is the sequencer side.
interface ks_add_sequencer_if;
  logic [7:0] in_data;
  logic       in_op;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       out_carry;
  logic       out_ovf;

  modport master (
    output in_data, in_op, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_carry, out_ovf
  );

  modport slave (
    input  in_data, in_op, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, out_carry, out_ovf
  );
endinterface

// File: rtl/ks_add_sequencer.sv
// Byte-serial multi-byte add/subtract sequencer driving a shared 8-bit adder.
// Loads A then B (LSB byte first), steps the adder once per byte with carry
// chaining, then streams the result LSB first with final carry/overflow flags.
module ks_add_sequencer #(
  parameter int unsigned NBYTES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  ks_add_sequencer_if.slave bus,
  output logic              busy,
  output logic [7:0]        adder_a,
  output logic [7:0]        adder_b,
  output logic              adder_cin,
  input  logic [7:0]        adder_sum,
  input  logic              adder_cout
);
  localparam int unsigned CW = $clog2(NBYTES) + 1;

  typedef enum logic [1:0] {LOAD_A, LOAD_B, COMPUTE, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          idx_q, idx_d;
  logic [NBYTES-1:0][7:0] a_buf, b_buf, r_buf;
  logic                   op_q, carry_q, carry_flag_q, ovf_q;
  logic [7:0]             a_sel, b_sel, r_sel;
  logic                   idx_last, accept;

  assign idx_last      = (idx_q == CW'(NBYTES - 1));
  assign bus.out_carry = carry_flag_q;
  assign bus.out_ovf   = ovf_q;

  // Select the current byte of each buffer by the byte counter
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    r_sel = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (idx_q == CW'(i)) begin
        a_sel = a_buf[i];
        b_sel = b_buf[i];
        r_sel = r_buf[i];
      end
    end
  end

  // Next-state, byte counter and decoded outputs
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    accept        = 1'b0;
    busy          = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    adder_a       = '0;
    adder_b       = '0;
    adder_cin     = 1'b0;
    case (state_q)
      LOAD_A: begin
        bus.in_ready = ena;
        accept       = ena & bus.in_valid;
        if (accept) begin
          if (idx_last) begin
            idx_d   = '0;
            state_d = LOAD_B;
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      end
      LOAD_B: begin
        bus.in_ready = ena;
        accept       = ena & bus.in_valid;
        if (accept) begin
          if (idx_last) begin
            idx_d   = '0;
            state_d = COMPUTE;
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      end
      COMPUTE: begin
        busy      = 1'b1;
        adder_a   = a_sel;
        adder_b   = op_q ? ~b_sel : b_sel;
        adder_cin = (idx_q == '0) ? op_q : carry_q;
        if (ena) begin
          if (idx_last) begin
            idx_d   = '0;
            state_d = DRAIN;
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        bus.out_data  = r_sel;
        bus.out_last  = idx_last;
        if (ena && bus.out_ready) begin
          if (idx_last) begin
            idx_d   = '0;
            state_d = LOAD_A;
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = LOAD_A;
        idx_d   = '0;
      end
    endcase
  end

  // State and byte counter; frozen while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD_A;
      idx_q   <= '0;
    end else if (ena) begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Operand/result buffers, carry chain and final flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_buf        <= '0;
      b_buf        <= '0;
      r_buf        <= '0;
      op_q         <= 1'b0;
      carry_q      <= 1'b0;
      carry_flag_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else if (ena) begin
      if (accept) begin
        for (int unsigned i = 0; i < NBYTES; i++) begin
          if (idx_q == CW'(i)) begin
            if (state_q == LOAD_A) a_buf[i] <= bus.in_data;
            else                   b_buf[i] <= bus.in_data;
          end
        end
        if (state_q == LOAD_A && idx_q == '0) op_q <= bus.in_op;
      end
      if (state_q == COMPUTE) begin
        for (int unsigned i = 0; i < NBYTES; i++) begin
          if (idx_q == CW'(i)) r_buf[i] <= adder_sum;
        end
        carry_q <= adder_cout;
        if (idx_last) begin
          carry_flag_q <= adder_cout;
          ovf_q        <= (adder_a[7] == adder_b[7]) && (adder_sum[7] != adder_a[7]);
        end
      end
    end
  end
endmodule

// File: tb/tb_ks_add_sequencer.sv
// Self-checking bench for ks_add_sequencer with NBYTES=4 and a behavioural 8-bit adder.
module tb_ks_add_sequencer;
  localparam int unsigned NB = 4;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       carry;
    logic       ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        busy;
  logic [7:0]  adder_a, adder_b, adder_sum;
  logic        adder_cin, adder_cout;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned accept_cyc = 0;
  int unsigned rx_count = 0;
  exp_t        sb[$];

  ks_add_sequencer_if bus();

  ks_add_sequencer #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .bus       (bus.slave),
    .busy      (busy),
    .adder_a   (adder_a),
    .adder_b   (adder_b),
    .adder_cin (adder_cin),
    .adder_sum (adder_sum),
    .adder_cout(adder_cout)
  );

  // Reference 8-bit adder standing in for the Kogge-Stone instance
  assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {8'b0, adder_cin};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Full-width model of the operation; pushes one expected entry per result byte
  task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input logic op);
    logic [32:0] full;
    logic        carry, ovf;
    exp_t        e;
    if (!op) begin
      full  = {1'b0, a} + {1'b0, b};
      carry = full[32];
      ovf   = (a[31] == b[31]) && (full[31] != a[31]);
    end else begin
      full  = {1'b0, a} - {1'b0, b};
      carry = ~full[32];
      ovf   = (a[31] != b[31]) && (full[31] != a[31]);
    end
    for (int i = 0; i < NB; i++) begin
      e.data  = full[8*i +: 8];
      e.last  = (i == NB - 1);
      e.carry = carry;
      e.ovf   = ovf;
      sb.push_back(e);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic op);
    int unsigned w;
    w = 0;
    bus.in_data  = d;
    bus.in_op    = op;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && w < 100) begin
      w++;
      @(negedge clk);
    end
    if (!bus.in_ready) check("in_timeout", 32'(bus.in_ready), 1);
    else accept_cyc = cyc;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_operands(input logic [31:0] a, input logic [31:0] b, input logic op);
    for (int i = 0; i < NB; i++) send_byte(a[8*i +: 8], (i == 0) ? op : ~op);
    for (int i = 0; i < NB; i++) send_byte(b[8*i +: 8], ~op);
  endtask

  // Push expectations, load operands, check the first compute step
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic op);
    push_exp(a, b, op);
    send_operands(a, b, op);
    check("cin_first", 32'(adder_cin), 32'(op));
    check("busy_compute", 32'(busy), 1);
    check("in_ready_compute", 32'(bus.in_ready), 0);
  endtask

  task automatic wait_empty();
    int unsigned w;
    w = 0;
    while (sb.size() != 0 && w < 200) begin
      w++;
      @(posedge clk);
    end
    check("drain_timeout", 32'(sb.size()), 0);
    #1;
  endtask

  // Scoreboard side: compare each consumed result byte
  always @(negedge clk) begin
    if (rst_n && ena && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", 32'(bus.out_valid), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", 32'(bus.out_data), 32'(e.data));
        check("out_last", 32'(bus.out_last), 32'(e.last));
        if (e.last) begin
          check("out_carry", 32'(bus.out_carry), 32'(e.carry));
          check("out_ovf", 32'(bus.out_ovf), 32'(e.ovf));
        end
      end
      rx_count++;
    end
  end

  initial begin
    int unsigned w;
    int unsigned base;
    rst_n         = 1'b0;
    ena           = 1'b1;
    bus.in_data   = '0;
    bus.in_op     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_last", 32'(bus.out_last), 0);
    check("rst_out_carry", 32'(bus.out_carry), 0);
    check("rst_out_ovf", 32'(bus.out_ovf), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_adder", {15'b0, adder_cin, adder_a, adder_b}, 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: plain add with latency measurement
    run_op(32'h12345678, 32'h11111111, 1'b0);
    w = 0;
    while (!bus.out_valid && w < 50) begin
      w++;
      @(negedge clk);
    end
    check("latency", cyc - accept_cyc, 5);
    wait_empty();

    // 2, 3: carry out and signed overflow corners
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0);
    wait_empty();
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0);
    wait_empty();
    run_op(32'h80000000, 32'h00000001, 1'b1);
    wait_empty();

    // 4: subtract with borrow
    run_op(32'h00000005, 32'h00000007, 1'b1);
    wait_empty();

    // 5: same operands without stalls, then with ena and out_ready stalls
    run_op(32'hDEADBEEF, 32'h0F1E2D3C, 1'b1);
    wait_empty();
    push_exp(32'hDEADBEEF, 32'h0F1E2D3C, 1'b1);
    for (int i = 0; i < NB; i++) send_byte(8'hEF >> 0 == 8'hEF && i == 0 ? 8'hEF :
                                           (i == 1 ? 8'hBE : (i == 2 ? 8'hAD : 8'hDE)),
                                           (i == 0) ? 1'b1 : 1'b0);
    send_byte(8'h3C, 1'b0);
    send_byte(8'h2D, 1'b0);
    ena          = 1'b0;
    bus.in_data  = 8'h1E;
    bus.in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("ena_in_ready", 32'(bus.in_ready), 0);
    end
    @(posedge clk);
    #1 ena = 1'b1;
    send_byte(8'h1E, 1'b0);
    send_byte(8'h0F, 1'b0);
    base = rx_count;
    w = 0;
    while (rx_count < base + 1 && w < 50) begin
      w++;
      @(posedge clk);
    end
    #1 bus.out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_valid", 32'(bus.out_valid), 1);
      check("stall_data", 32'(bus.out_data), (sb.size() != 0) ? 32'(sb[0].data) : 32'hFFFF_FFFF);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_empty();

    // 6: reset in the middle of COMPUTE aborts the operation
    send_operands(32'h01020304, 32'h05060708, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 0);
    check("abort_out_carry", 32'(bus.out_carry), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_adder", {15'b0, adder_cin, adder_a, adder_b}, 0);
    check("abort_in_ready", 32'(bus.in_ready), 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 1);
    check("post_rst_out_valid", 32'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    run_op(32'h00000001, 32'h00000002, 1'b0);
    wait_empty();
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
